// File: rtl/uart_pkg.sv
// Shared UART constants, bit-timing helper and state encodings for the RX and TX sides.
// RX_PARITY_EN adds the PARITY state used by 8E1 framing.
package uart_pkg;

   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_P  = 8'h50;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_0  = 8'h30;

   // Integer truncation: 50 MHz / 115200 gives 434.
   function automatic int bit_cnt(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_WAIT_HI
   } rx_state_e;

   typedef enum logic [2:0] {
      P_IDLE,
      P_EOL_S,
      P_EOL_P,
      P_NUM,
      P_ERR
   } prs_state_e;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Serial input and command/threshold outputs of the host command receiver.
// master: the receiver side; slave: the FPGA top level that drives the line and consumes commands.
interface uart_cmd_rx_if;

   logic       uart_rx;
   logic [7:0] rx_byte;
   logic       rx_byte_vld;
   logic       cmd_start;
   logic       cmd_stop;
   logic [9:0] thr_cm;
   logic       thr_upd;
   logic       cmd_err;

   modport master (
      input  uart_rx,
      output rx_byte, rx_byte_vld, cmd_start, cmd_stop, thr_cm, thr_upd, cmd_err
   );

   modport slave (
      output uart_rx,
      input  rx_byte, rx_byte_vld, cmd_start, cmd_stop, thr_cm, thr_upd, cmd_err
   );

endinterface

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, RX FSM and mid-bit sampling.
// 8N1 by default; RX_PARITY_EN selects 8E1 with a parity check before the stop bit.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       vld_o,
   output logic       frame_err_o
);

   localparam int BIT_CNT = bit_cnt(CLK_HZ, BAUD);
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = $clog2(BIT_CNT + 1);

   logic             rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       byte_q, byte_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             par_err;
   logic             half_end, bit_end;

`ifdef RX_PARITY_EN
   logic par_err_q, par_err_d;
   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   assign half_end = (cnt_q == CNT_W'(HALF - 1));
   assign bit_end  = (cnt_q == CNT_W'(BIT_CNT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
`ifdef RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
`ifdef RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   // Shift register contents are only meaningful after a full frame, so it needs no reset.
   always_ff @(posedge clk) begin
      sh_q <= sh_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      byte_d  = byte_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
`ifdef RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) state_d = RX_START;
         end
         RX_START: begin
            if (half_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               sh_d  = {rx_s2_q, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = RX_PARITY;
`else
                  state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         RX_PARITY: begin
            if (bit_end) begin
               cnt_d     = '0;
               par_err_d = ^{sh_q, rx_s2_q};
               err_d     = ^{sh_q, rx_s2_q};
               state_d   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            // A parity error already reported this byte, so the stop check stays silent.
            if (bit_end) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  state_d = RX_IDLE;
                  if (!par_err) begin
                     byte_d = sh_q;
                     vld_d  = 1'b1;
                  end
               end else begin
                  state_d = RX_WAIT_HI;
                  err_d   = !par_err;
               end
            end
         end
         RX_WAIT_HI: begin
            cnt_d = '0;
            if (rx_s2_q) state_d = RX_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = RX_IDLE;
         end
      endcase
   end

   assign byte_o      = byte_q;
   assign vld_o       = vld_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses "S\n", "P\n" and "Tddd\n" lines from the UART byte stream.
// Define RX_PARITY_EN for 8E1 framing; the default build is 8N1.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int MAX_DIGITS = 3,
   parameter int THR_RESET  = 100
) (
   input  logic          clk,
   input  logic          rstn,
   uart_cmd_rx_if.master bus
);

   localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

   logic [7:0]  rx_byte;
   logic        rx_vld;
   logic        rx_err;

   prs_state_e  pst_q, pst_d;
   logic [9:0]  acc_q, acc_d;
   logic [NDIG_W-1:0] ndig_q, ndig_d;
   logic [9:0]  thr_q, thr_d;
   logic        start_q, start_d;
   logic        stop_q, stop_d;
   logic        upd_q, upd_d;
   logic        err_q, err_d;
   logic        enter_err;
   logic        is_digit;
   logic [3:0]  digit;

   uart_rx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clk         (clk),
      .rstn        (rstn),
      .rx_i        (bus.uart_rx),
      .byte_o      (rx_byte),
      .vld_o       (rx_vld),
      .frame_err_o (rx_err)
   );

   // Decimal accumulate, truncated to the 10-bit threshold width.
   function automatic logic [9:0] mac10(input logic [9:0] acc, input logic [3:0] d);
      logic [13:0] t;
      t = 14'(acc) * 14'd10 + 14'(d);
      return t[9:0];
   endfunction

   assign is_digit = (rx_byte >= CH_0) && (rx_byte <= CH_0 + 8'd9);
   assign digit    = 4'(rx_byte - CH_0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pst_q   <= P_IDLE;
         ndig_q  <= '0;
         thr_q   <= 10'(THR_RESET);
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pst_q   <= pst_d;
         ndig_q  <= ndig_d;
         thr_q   <= thr_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   // Cleared on every 'T', so the accumulator carries no reset.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   always_comb begin
      pst_d     = pst_q;
      acc_d     = acc_q;
      ndig_d    = ndig_q;
      thr_d     = thr_q;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      upd_d     = 1'b0;
      err_d     = 1'b0;
      enter_err = 1'b0;
      if (rx_err) begin
         pst_d = P_ERR;
         err_d = 1'b1;
      end else if (rx_vld && rx_byte != CH_CR) begin
         case (pst_q)
            P_IDLE: begin
               if (rx_byte == CH_S) pst_d = P_EOL_S;
               else if (rx_byte == CH_P) pst_d = P_EOL_P;
               else if (rx_byte == CH_T) begin
                  pst_d  = P_NUM;
                  acc_d  = '0;
                  ndig_d = '0;
               end else if (rx_byte != CH_LF) enter_err = 1'b1;
            end
            P_EOL_S: begin
               if (rx_byte == CH_LF) begin
                  start_d = 1'b1;
                  pst_d   = P_IDLE;
               end else enter_err = 1'b1;
            end
            P_EOL_P: begin
               if (rx_byte == CH_LF) begin
                  stop_d = 1'b1;
                  pst_d  = P_IDLE;
               end else enter_err = 1'b1;
            end
            P_NUM: begin
               if (is_digit) begin
                  if (ndig_q < NDIG_W'(MAX_DIGITS)) begin
                     acc_d  = mac10(acc_q, digit);
                     ndig_d = ndig_q + NDIG_W'(1);
                  end else enter_err = 1'b1;
               end else if (rx_byte == CH_LF && ndig_q != '0) begin
                  thr_d = acc_q;
                  upd_d = 1'b1;
                  pst_d = P_IDLE;
               end else enter_err = 1'b1;
            end
            P_ERR: begin
               if (rx_byte == CH_LF) pst_d = P_IDLE;
            end
            default: pst_d = P_IDLE;
         endcase
         if (enter_err) begin
            pst_d = P_ERR;
            err_d = 1'b1;
         end
      end
   end

   assign bus.rx_byte     = rx_byte;
   assign bus.rx_byte_vld = rx_vld;
   assign bus.cmd_start   = start_q;
   assign bus.cmd_stop    = stop_q;
   assign bus.thr_cm      = thr_q;
   assign bus.thr_upd     = upd_q;
   assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a bench UART drives command lines, a monitor pops expected events.
// Honours RX_PARITY_EN for 8E1 framing and the wrong-parity case.
module tb_uart_cmd_rx;
   import uart_pkg::*;

   localparam int CLK_HZ = 3_686_400;
   localparam int BAUD   = 115200;
   localparam int BC     = CLK_HZ / BAUD;

   localparam int EV_NONE  = 0;
   localparam int EV_BYTE  = 1;
   localparam int EV_START = 2;
   localparam int EV_STOP  = 3;
   localparam int EV_THR   = 4;
   localparam int EV_ERR   = 5;

   typedef struct {
      int k;
      int v;
   } ev_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   ev_t  q[$];

   always #5 clk = ~clk;

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .MAX_DIGITS (3),
      .THR_RESET  (100)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic chk(input string tag, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", tag, act, act, req, req);
      end
   endtask

   task automatic push(input int k, input int v);
      ev_t e;
      e.k = k;
      e.v = v;
      q.push_back(e);
   endtask

   task automatic take(input string tag, input int k, input int v);
      ev_t e;
      if (q.size() == 0) begin
         chk({"unexpected_", tag}, k, EV_NONE);
      end else begin
         e = q.pop_front();
         chk({"kind_", tag}, k, e.k);
         if (k == EV_BYTE || k == EV_THR) chk({"val_", tag}, v, e.v);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.rx_byte_vld) take("byte", EV_BYTE, int'(bus.rx_byte));
         if (bus.cmd_start)   take("start", EV_START, 0);
         if (bus.cmd_stop)    take("stop", EV_STOP, 0);
         if (bus.thr_upd)     take("thr", EV_THR, int'(bus.thr_cm));
         if (bus.cmd_err)     take("err", EV_ERR, 0);
      end
   end

   task automatic line_bit(input logic b);
      bus.uart_rx = b;
      repeat (BC) @(posedge clk);
   endtask

   // Expectations go into the queue before the frame goes on the wire.
   task automatic send(input logic [7:0] b, input logic stop_b, input logic par_flip,
                       input int ek, input int ev);
      if (stop_b && !par_flip) push(EV_BYTE, int'(b));
      if (ek != EV_NONE) push(ek, ev);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef RX_PARITY_EN
      line_bit((^b) ^ par_flip);
`endif
      line_bit(stop_b);
   endtask

   task automatic send_str(input string s, input int last_k, input int last_v);
      for (int i = 0; i < s.len(); i++)
         send(s[i], 1'b1, 1'b0, (i == s.len() - 1) ? last_k : EV_NONE, last_v);
   endtask

   task automatic settle(input string tag);
      repeat (2 * BC) @(posedge clk);
      chk({"drain_", tag}, q.size(), 0);
      q.delete();
   endtask

   initial begin
      #800us;
      $display("FAIL watchdog: simulation time limit reached, got 0 required 1");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.uart_rx = 1'b1;
      rstn = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_byte", int'(bus.rx_byte), 0);
      chk("rst_thr", int'(bus.thr_cm), 100);
      chk("rst_pulses", int'({bus.rx_byte_vld, bus.cmd_start, bus.cmd_stop, bus.thr_upd, bus.cmd_err}), 0);
      rstn = 1'b1;
      repeat (4) @(posedge clk);

      send_str("S\n", EV_START, 0);
      settle("S");

      send_str("T250", EV_NONE, 0);
      send(CH_CR, 1'b1, 1'b0, EV_NONE, 0);
      send(CH_LF, 1'b1, 1'b0, EV_THR, 250);
      settle("T250");
      @(negedge clk);
      chk("thr_250", int'(bus.thr_cm), 250);

      send_str("T7\n", EV_THR, 7);
      settle("T7");
      @(negedge clk);
      chk("thr_7", int'(bus.thr_cm), 7);

      send_str("T123", EV_NONE, 0);
      send("4", 1'b1, 1'b0, EV_ERR, 0);
      send(CH_LF, 1'b1, 1'b0, EV_NONE, 0);
      settle("T1234");
      @(negedge clk);
      chk("thr_after_overflow", int'(bus.thr_cm), 7);
      send_str("P\n", EV_STOP, 0);
      settle("P");

      // Bad stop bit, then the line stays low for three more bit times.
      send(CH_S, 1'b0, 1'b0, EV_ERR, 0);
      bus.uart_rx = 1'b0;
      repeat (3 * BC) @(posedge clk);
      bus.uart_rx = 1'b1;
      repeat (BC) @(posedge clk);
      @(negedge clk);
      chk("rx_byte_hold", int'(bus.rx_byte), int'(CH_LF));
      send(CH_LF, 1'b1, 1'b0, EV_NONE, 0);
      settle("framing");

      bus.uart_rx = 1'b0;
      repeat (10) @(posedge clk);
      bus.uart_rx = 1'b1;
      repeat (4 * BC) @(posedge clk);
      settle("glitch");

      send_str("T4", EV_NONE, 0);
      line_bit(1'b0);
      line_bit(1'b1);
      line_bit(1'b0);
      @(negedge clk);
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      bus.uart_rx = 1'b1;
      @(negedge clk);
      chk("midframe_rst_thr", int'(bus.thr_cm), 100);
      chk("midframe_rst_byte", int'(bus.rx_byte), 0);
      rstn = 1'b1;
      repeat (2 * BC) @(posedge clk);
      settle("reset");
      send_str("T9\n", EV_THR, 9);
      settle("T9");
      @(negedge clk);
      chk("thr_9", int'(bus.thr_cm), 9);

`ifdef RX_PARITY_EN
      send(CH_S, 1'b1, 1'b1, EV_ERR, 0);
      send(CH_LF, 1'b1, 1'b0, EV_NONE, 0);
      settle("parity");
      send_str("S\n", EV_START, 0);
      settle("S_after_parity");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
